// File: rtl/kbd_input_fifo_if.sv
// Keyboard FIFO bus: pad data/strobe and CPU pop/clear in, head byte and status out.
// The master side is the pads plus the CPU; the slave side is the FIFO itself.
interface kbd_input_fifo_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] key_in;
    logic             key_strobe;
    logic             rd;
    logic             clr_ovr;
    logic [WIDTH-1:0] key_out;
    logic             key_valid;
    logic             full;
    logic [CW-1:0]    count;
    logic             overrun;

    modport master (
        output key_in, key_strobe, rd, clr_ovr,
        input  key_out, key_valid, full, count, overrun
    );

    modport slave (
        input  key_in, key_strobe, rd, clr_ovr,
        output key_out, key_valid, full, count, overrun
    );
endinterface

// File: rtl/kbd_input_fifo.sv
// Keyboard front-end: synchronises the asynchronous key strobe, captures one
// byte per strobe rising edge and buffers it in a first-word-fall-through FIFO
// that the CPU drains one byte per read. Occupancy count is the only
// full/empty discriminator; pointers wrap naturally at DEPTH.
module kbd_input_fifo #(
    parameter int DEPTH       = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    kbd_input_fifo_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overrun_q, overrun_d;

    logic strobe_edge;
    logic is_full;
    logic not_empty;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Strobe synchroniser shift and edge history; a rise is seen once the
    // last sync stage is high while the history flop still holds the old low.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.key_strobe};
        hist_d      = sync_q[SYNC_STAGES-1];
        strobe_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Push/pop/drop decisions; a pop frees a slot so a push into a full FIFO
    // is still accepted, while a pop on an empty FIFO is ignored outright.
    always_comb begin
        is_full   = (count_q == CW'(DEPTH));
        not_empty = (count_q != '0);
        do_pop    = bus.rd & not_empty;
        do_push   = strobe_edge & (~is_full | do_pop);
        do_drop   = strobe_edge & is_full & ~do_pop;
    end

    // Next-state for storage, pointers, occupancy and the sticky overrun flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = bus.key_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        if (do_drop) begin
            overrun_d = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers; sync and history reset high so a strobe held across
    // reset release is not mistaken for a new key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            hist_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs come only from registered state, so no input-to-output paths.
    always_comb begin
        bus.key_valid = not_empty;
        bus.full      = is_full;
        bus.count     = count_q;
        bus.overrun   = overrun_q;
        bus.key_out   = not_empty ? mem_q[rd_ptr_q] : '0;
    end
endmodule

// File: tb/tb_kbd_input_fifo.sv
// Testbench for kbd_input_fifo: directed scenarios plus a randomised
// interleaved push/pop run, checked every cycle against a queue-based model.
module tb_kbd_input_fifo;
    localparam int DEPTH       = 4;
    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;

    kbd_input_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    kbd_input_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] modelQ[$];
    logic             modelOvr;
    int               cycle;
    int               edgeCycle;
    int               checks;
    int               errors;

    // Compares every DUT output with what the model queue says it should be.
    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] expOut;
        logic [CW-1:0]    expCount;
        expOut   = (modelQ.size() != 0) ? modelQ[0] : '0;
        expCount = CW'(modelQ.size());
        checks++;
        assert (bus.key_out === expOut) else begin
            errors++;
            $error("[TB] FAIL %s key_out: observed %h expected %h", tag, bus.key_out, expOut);
        end
        checks++;
        assert (bus.key_valid === (modelQ.size() != 0)) else begin
            errors++;
            $error("[TB] FAIL %s key_valid: observed %b expected %b", tag, bus.key_valid, modelQ.size() != 0);
        end
        checks++;
        assert (bus.full === (modelQ.size() == DEPTH)) else begin
            errors++;
            $error("[TB] FAIL %s full: observed %b expected %b", tag, bus.full, modelQ.size() == DEPTH);
        end
        checks++;
        assert (bus.count === expCount) else begin
            errors++;
            $error("[TB] FAIL %s count: observed %0d expected %0d", tag, bus.count, expCount);
        end
        checks++;
        assert (bus.overrun === modelOvr) else begin
            errors++;
            $error("[TB] FAIL %s overrun: observed %b expected %b", tag, bus.overrun, modelOvr);
        end
    endtask

    // One clock: drive rd/clr_ovr, advance the model at the edge, then check.
    // A key rise is registered as a push SYNC_STAGES+1 edges after the strobe
    // first gets sampled high; a full FIFO accepts it only if a pop coincides.
    task automatic applyStimulus(input logic rdV, input logic clrV, input string tag);
        logic edgeNow;
        logic popM;
        logic pushM;
        bus.rd      = rdV;
        bus.clr_ovr = clrV;
        @(posedge clk);
        cycle++;
        edgeNow = (cycle == edgeCycle);
        popM    = rdV && (modelQ.size() != 0);
        pushM   = edgeNow && ((modelQ.size() < DEPTH) || popM);
        if (edgeNow && !pushM) begin
            modelOvr = 1'b1;
        end else if (clrV) begin
            modelOvr = 1'b0;
        end
        if (popM) void'(modelQ.pop_front());
        if (pushM) modelQ.push_back(bus.key_in);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    // One keystroke: strobe high for 4 clocks with data held, then low for 3.
    // rdMode: 0 no reads, 1 read only on the push edge, 2 read held, 3 random.
    task automatic pressKey(input logic [WIDTH-1:0] data, input int rdMode,
                            input logic clrOnEdge, input string tag);
        logic rdV;
        bus.key_in     = data;
        bus.key_strobe = 1'b1;
        edgeCycle      = cycle + SYNC_STAGES + 1;
        for (int i = 1; i <= 7; i++) begin
            if (i == 5) bus.key_strobe = 1'b0;
            case (rdMode)
                1:       rdV = (i == SYNC_STAGES + 1);
                2:       rdV = 1'b1;
                3:       rdV = 1'($urandom_range(0, 1));
                default: rdV = 1'b0;
            endcase
            applyStimulus(rdV, clrOnEdge && (i == SYNC_STAGES + 1), tag);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        edgeCycle = -1;
        modelOvr  = 1'b0;
        modelQ.delete();

        // Reset with strobe already high.
        rst            = 1'b1;
        bus.key_in     = '0;
        bus.key_strobe = 1'b1;
        bus.rd         = 1'b0;
        bus.clr_ovr    = 1'b0;
        #1;
        checkOutput("reset");
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_hold");
        rst = 1'b0;

        // Strobe held across release must not push.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, "strobe_held");
        bus.key_strobe = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "strobe_low");
        pressKey(8'h41, 0, 1'b0, "first_key");
        applyStimulus(1'b1, 1'b0, "pop_first");

        // Fill with four keys, then drain in order.
        pressKey(8'h10, 0, 1'b0, "fill");
        pressKey(8'h20, 0, 1'b0, "fill");
        pressKey(8'h30, 0, 1'b0, "fill");
        pressKey(8'h40, 0, 1'b0, "fill");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, "drain");
        applyStimulus(1'b0, 1'b0, "drained");

        // Overrun set, clear, and set-wins-over-clear.
        pressKey(8'h11, 0, 1'b0, "refill");
        pressKey(8'h22, 0, 1'b0, "refill");
        pressKey(8'h33, 0, 1'b0, "refill");
        pressKey(8'h44, 0, 1'b0, "refill");
        pressKey(8'h55, 0, 1'b0, "drop");
        applyStimulus(1'b0, 1'b1, "clr_ovr");
        pressKey(8'h66, 0, 1'b1, "drop_vs_clr");
        applyStimulus(1'b0, 1'b1, "clr_ovr2");

        // Full FIFO: push edge coincides with a pop.
        pressKey(8'h77, 1, 1'b0, "full_push_pop");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, "drain2");
        applyStimulus(1'b0, 1'b0, "drained2");

        // Empty FIFO with rd held while a key arrives.
        pressKey(8'h7E, 2, 1'b0, "rd_hold_empty");
        applyStimulus(1'b0, 1'b0, "after_hold");

        // Randomised interleaving across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            pressKey(WIDTH'($urandom), 3, 1'b0, "random");
        end
        pressKey(WIDTH'($urandom), 0, 1'b0, "pre_reset");
        pressKey(WIDTH'($urandom), 0, 1'b0, "pre_reset");

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        modelQ.delete();
        modelOvr  = 1'b0;
        edgeCycle = -1;
        #1;
        checkOutput("async_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "post_reset");
        pressKey(8'h5A, 0, 1'b0, "recover");
        applyStimulus(1'b1, 1'b0, "recover_pop");

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
